two_way_mux_unit: RTL and testbench

//  2:1 selector: y = s ? d1 : d0, WIDTH bits wide. Also provides a registered copy of
//  the output and select, for datapath slices that need a timing-clean mux result.

---
 rtl/two_way_mux_unit_if.sv | 31 +++
 rtl/two_way_mux_unit.sv | 65 ++++++
 tb/tb_two_way_mux_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/two_way_mux_unit_if.sv
// two_way_mux_unit_if
// Bundles the data, select and result signals of two_way_mux_unit.
//   d0, d1      WIDTH  data inputs (d0 chosen when s=0, d1 when s=1)
//   s           1      select
//   y           WIDTH  combinational mux result
//   y_q         WIDTH  y registered one cycle
//   s_q         1      s registered one cycle
//   toggle_cnt  CNT_W  select-edge counter (zero unless TWO_WAY_MUX_STATS_EN)
// Modports: master drives d0/d1/s and observes the results; slave is the mux.
interface two_way_mux_unit_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             s;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             s_q;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output d0, d1, s,
    input  y, y_q, s_q, toggle_cnt
  );

  modport slave (
    input  d0, d1, s,
    output y, y_q, s_q, toggle_cnt
  );
endinterface

// File: rtl/two_way_mux_unit.sv
// two_way_mux_unit
// 2:1 selector y = s ? d1 : d0 (WIDTH bits), plus a registered copy of the
// result and of the select for slices that want a timing-clean mux output.
// Ports:
//   clk   in  single clock, all state updates on the rising edge
//   rst   in  asynchronous, active-high reset (clears y_q, s_q, toggle_cnt)
//   bus   slave modport of two_way_mux_unit_if (d0, d1, s, y, y_q, s_q,
//         toggle_cnt)
// Optional feature: define TWO_WAY_MUX_STATS_EN to build a saturating counter
// of select changes on toggle_cnt; without it toggle_cnt is tied to zero.
// The WIDTH/CNT_W parameters must match those of the connected interface.
module two_way_mux_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  two_way_mux_unit_if.slave bus
);

  logic [WIDTH-1:0] y_c;
  logic [WIDTH-1:0] y_r;
  logic             s_r;

  // The combinational result is deliberately not gated by rst; an X/Z select
  // simply follows the ?: operator rules.
  assign y_c   = bus.s ? bus.d1 : bus.d0;
  assign bus.y = y_c;

  // Output and select pipeline registers: update every cycle, no enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r <= '0;
      s_r <= 1'b0;
    end else begin
      y_r <= y_c;
      s_r <= bus.s;
    end
  end

  assign bus.y_q = y_r;
  assign bus.s_q = s_r;

`ifdef TWO_WAY_MUX_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_r;

  // A select edge is seen when the live select differs from the registered
  // one; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if ((bus.s != s_r) && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign bus.toggle_cnt = cnt_r;
`else
  assign bus.toggle_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_two_way_mux_unit.sv
// tb_two_way_mux_unit
// Directed bench for two_way_mux_unit: a WIDTH=1 instance for the truth table
// and a WIDTH=8, CNT_W=2 instance for registered outputs, async reset and the
// optional select-toggle counter (TWO_WAY_MUX_STATS_EN).
module tb_two_way_mux_unit;

  logic clk;
  logic rst;

  int assert_count;
  int fail_count;

  two_way_mux_unit_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
  two_way_mux_unit_if #(.WIDTH(8), .CNT_W(2)) bus8 ();

  two_way_mux_unit #(.WIDTH(1), .CNT_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  two_way_mux_unit #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive the 8-bit instance inputs.
  task automatic applyStimulus(input logic [7:0] d0_v, input logic [7:0] d1_v,
                               input logic s_v);
    bus8.d0 = d0_v;
    bus8.d1 = d1_v;
    bus8.s  = s_v;
  endtask

  logic [7:0] truth_exp;
  logic [1:0] cnt_exp [5];

  initial begin
    assert_count = 0;
    fail_count   = 0;
    truth_exp    = 8'b1100_1010;  // bit i = required y for {s,d1,d0} = i
    cnt_exp      = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst     = 1'b1;
    bus1.d0 = 1'b0;
    bus1.d1 = 1'b0;
    bus1.s  = 1'b0;
    applyStimulus(8'h00, 8'h00, 1'b0);
    #1;
    checkOutput("reset_y_q8", 32'(bus8.y_q), 32'h0);
    checkOutput("reset_s_q8", 32'(bus8.s_q), 32'h0);
    checkOutput("reset_cnt8", 32'(bus8.toggle_cnt), 32'h0);
    checkOutput("reset_y_q1", 32'(bus1.y_q), 32'h0);

    // Truth table while reset is still held: y must not be gated by rst.
    for (int i = 0; i < 8; i++) begin
      bus1.s  = i[2];
      bus1.d1 = i[1];
      bus1.d0 = i[0];
      #10;
      checkOutput($sformatf("truth_%0d", i), 32'(bus1.y), 32'(truth_exp[i]));
    end
    checkOutput("reset_hold_y_q1", 32'(bus1.y_q), 32'h0);

    @(negedge clk);
    rst = 1'b0;

    // 8-bit selection and one-cycle registered copy.
    @(negedge clk);
    applyStimulus(8'hA5, 8'h3C, 1'b0);
    #1;
    checkOutput("y_s0", 32'(bus8.y), 32'hA5);
    @(negedge clk);
    checkOutput("y_q_s0", 32'(bus8.y_q), 32'hA5);
    checkOutput("s_q_s0", 32'(bus8.s_q), 32'h0);
    applyStimulus(8'hA5, 8'h3C, 1'b1);
    #1;
    checkOutput("y_s1", 32'(bus8.y), 32'h3C);
    checkOutput("y_q_before_edge", 32'(bus8.y_q), 32'hA5);
    @(negedge clk);
    checkOutput("y_q_s1", 32'(bus8.y_q), 32'h3C);
    checkOutput("s_q_s1", 32'(bus8.s_q), 32'h1);

    // Asynchronous reset mid-stream, well away from any rising edge.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_y_q", 32'(bus8.y_q), 32'h0);
    checkOutput("async_s_q", 32'(bus8.s_q), 32'h0);
    checkOutput("async_cnt", 32'(bus8.toggle_cnt), 32'h0);
    applyStimulus(8'hA5, 8'h77, 1'b1);
    #1;
    checkOutput("rst_y_track_d1", 32'(bus8.y), 32'h77);
    applyStimulus(8'h5A, 8'h77, 1'b0);
    #1;
    checkOutput("rst_y_track_d0", 32'(bus8.y), 32'h5A);

    // Release, then first capture on the following rising edge.
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h00, 8'h01, 1'b1);
    bus1.s  = 1'b1;
    bus1.d1 = 1'b1;
    bus1.d0 = 1'b0;
    #1;
    checkOutput("release_no_capture", 32'(bus8.y_q), 32'h0);
    @(negedge clk);
    checkOutput("release_y_q8", 32'(bus8.y_q), 32'h01);
    checkOutput("release_s_q8", 32'(bus8.s_q), 32'h1);
    checkOutput("release_y_q1", 32'(bus1.y_q), 32'h1);

    // Select toggling every cycle from a freshly cleared state.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(8'h11, 8'h22, 1'b0);
    #1;
    checkOutput("cnt_cleared", 32'(bus8.toggle_cnt), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(8'h11, 8'h22, (k % 2) == 0);
      @(negedge clk);
      checkOutput($sformatf("toggle_s_q_%0d", k), 32'(bus8.s_q),
                  ((k % 2) == 0) ? 32'h1 : 32'h0);
`ifdef TWO_WAY_MUX_STATS_EN
      checkOutput($sformatf("toggle_cnt_%0d", k), 32'(bus8.toggle_cnt),
                  32'(cnt_exp[k]));
`else
      checkOutput($sformatf("toggle_cnt_%0d", k), 32'(bus8.toggle_cnt),
                  32'h0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
